data_memory_manager: RTL and testbench
======================================

DATA_MEMORY_MANAGER -- requirements
Module: DataMemoryManager

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port address_i, input, 32 bits: word address; bits [17:16] select bank, bits [11:0] select word in bank.
REQ-004 SHALL have port data_i, input, 32 bits: write data.
REQ-005 SHALL have port wren_i, input, 1 bit: write enable, sampled at rising CLK.
REQ-006 SHALL have port byte_mode_i, input, 1 bit: 0 = 32-bit word access, 1 = low-byte access.
REQ-007 SHALL have port data_o, output, 32 bits: registered read data.
REQ-008 SHALL have parameter BANK_DEPTH, default 4096: words per bank.
REQ-009 SHALL have parameter BANK_AW, default 12: bank word-address width, log2(BANK_DEPTH).

Function
REQ-010 SHALL contain three independent 32-bit-wide banks, each with byte-lane write enables.
REQ-011 SHALL map address_i[17:16]=00 to bank 0, 01 to bank 1 and 10 to bank 2.
REQ-012 SHALL treat any address with address_i[31:18]!=0, address_i[17:16]=11, or address_i[15:BANK_AW]!=0 as unmapped.
REQ-013 SHALL perform a write on a rising CLK with wren_i=1 to the decoded bank and word only; other banks are unchanged.
REQ-014 SHALL, for a word write (byte_mode_i=0), use byte-enable 4'b1111 and store data_i[31:0].
REQ-015 SHALL, for a byte write (byte_mode_i=1), use byte-enable 4'b0001 and store data_i[7:0] in bits [7:0]; bits [31:8] keep their previous value.
REQ-016 SHALL ignore writes to unmapped addresses; no bank changes.
REQ-017 SHALL register address, bank select and byte_mode at edge N, read the bank array at edge N+1 and drive data_o from that value; data_o is stable after the second rising edge following address presentation (read latency 2).
REQ-018 SHALL perform reads every cycle regardless of wren_i.
REQ-019 SHALL, on a same-address read during write, return the old (pre-write) data (read-before-write).
REQ-020 SHALL, in byte mode, return {24'h0, word[7:0]} as read data (zero-extended).
REQ-021 SHALL return 32'h0 for reads of unmapped addresses with the same latency as mapped reads.
REQ-022 SHALL select the output bank using the registered bank select, delayed to align with array read data, so that back-to-back reads to different banks return correct data each cycle.
REQ-023 SHALL start a new read every cycle (full throughput); consecutive addresses produce data_o values in order, each 2 edges later.

Reset
REQ-024 SHALL, while RST_n=0, asynchronously force data_o, the registered address, the bank select and the byte_mode pipeline to 0.
REQ-025 SHALL NOT clear bank contents on reset; contents are undefined until written.
REQ-026 SHALL block writes while RST_n=0; after RST_n deasserts, the first rising edge operates normally.
REQ-027 SHALL, if reset is asserted mid-read, discard the in-flight read; data_o stays 0 until a new read completes 2 edges after release.

Verification
REQ-028 SHALL cover this scenario: word writes data=i at addresses 0x0..0x0E, 0x10000..0x1000E and 0x20000..0x2000E, then reads of each address with 2 edges per read -> data_o equals the address value (e.g. 0x10005 -> 0x00010005).
REQ-029 SHALL cover this scenario: word write 0xAABBCCDD at 0x3, then byte write 0x11223344 at 0x3, then word read -> 0xAABBCC44; byte read -> 0x00000044.
REQ-030 SHALL cover this scenario: write 0x12345678 at 0x30000 (unmapped), then read 0x30000 -> data_o 0x0, and banks 0..2 word 0 are unchanged.
REQ-031 SHALL cover this scenario: back-to-back reads 0x1, 0x10001, 0x20001 on consecutive edges -> data_o 0x1, 0x10001, 0x20001 on consecutive edges, starting at the second edge.
REQ-032 SHALL cover this scenario: RST_n pulsed low between clock edges during a read -> data_o goes 0 immediately; a write attempted during reset leaves memory unchanged.
REQ-033 SHALL cover this scenario: write 0x55 to address 0x7 while reading 0x7 in the same cycle -> data_o shows the old value, and the next read shows 0x55.

Source files
------------

// File: rtl/data_memory_manager.sv
// rtl/data_memory_manager.sv - three-bank data memory, byte-lane writes, two-edge registered read
module data_memory_manager #(
  parameter int BANK_DEPTH = 4096,
  parameter int BANK_AW    = 12
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        wren_i,
  input  logic        byte_mode_i,
  output logic [31:0] data_o
);

  logic [15:0]        upper_bits;
  logic               mapped;

  logic [BANK_AW-1:0] addr_q;
  logic [1:0]         bank_q;
  logic               byte_q;
  logic               mapped_q;
  logic               wren_q;
  logic [31:0]        wdata_q;

  logic [1:0]         bank_q2;
  logic               byte_q2;
  logic               valid_q2;

  logic [31:0]        rd_word [3];
  logic [31:0]        sel_word;

  assign upper_bits = address_i[15:0] >> BANK_AW;
  assign mapped     = (address_i[31:18] == 14'h0) && (address_i[17:16] != 2'b11)
                      && (upper_bits == 16'h0);

  // Writes are staged with the address so they land on the same edge as the
  // array read, which gives read-before-write for a colliding address.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      addr_q   <= '0;
      bank_q   <= 2'b00;
      byte_q   <= 1'b0;
      mapped_q <= 1'b0;
      wren_q   <= 1'b0;
      wdata_q  <= 32'h0;
    end else begin
      addr_q   <= address_i[BANK_AW-1:0];
      bank_q   <= address_i[17:16];
      byte_q   <= byte_mode_i;
      mapped_q <= mapped;
      wren_q   <= wren_i;
      wdata_q  <= data_i;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_bank
    logic [31:0] mem [BANK_DEPTH];
    logic [31:0] rd_q;
    logic        we;

    assign we = wren_q && mapped_q && (bank_q == 2'(b));

    always_ff @(posedge CLK) begin
      if (we) begin
        mem[addr_q][7:0] <= wdata_q[7:0];
        if (!byte_q) begin
          mem[addr_q][31:8] <= wdata_q[31:8];
        end
      end
      rd_q <= mem[addr_q];
    end

    assign rd_word[b] = rd_q;
  end

  // Bank select and mode travel alongside the array read so every cycle's
  // output picks the bank that cycle's address decoded to.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bank_q2  <= 2'b00;
      byte_q2  <= 1'b0;
      valid_q2 <= 1'b0;
    end else begin
      bank_q2  <= bank_q;
      byte_q2  <= byte_q;
      valid_q2 <= mapped_q;
    end
  end

  always_comb begin
    sel_word = 32'h0;
    case (bank_q2)
      2'b00:   sel_word = rd_word[0];
      2'b01:   sel_word = rd_word[1];
      2'b10:   sel_word = rd_word[2];
      default: sel_word = 32'h0;
    endcase
  end

  always_comb begin
    data_o = 32'h0;
    if (valid_q2) begin
      data_o = byte_q2 ? {24'h0, sel_word[7:0]} : sel_word;
    end
  end

endmodule

// File: tb/tb_data_memory_manager.sv
// tb/tb_data_memory_manager.sv - directed self-checking bench for data_memory_manager
module tb_data_memory_manager;

  logic        CLK;
  logic        RST_n;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        wren_i;
  logic        byte_mode_i;
  logic [31:0] data_o;

  int checks;
  int failures;

  data_memory_manager dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .address_i  (address_i),
    .data_i     (data_i),
    .wren_i     (wren_i),
    .byte_mode_i(byte_mode_i),
    .data_o     (data_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Present one set of inputs, let one rising edge take them, return 1 time unit later.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic bm);
    address_i   = a;
    data_i      = d;
    wren_i      = w;
    byte_mode_i = bm;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic bm,
                           input logic [31:0] exp);
    step(a, 32'h0, 1'b0, bm);
    idle();
    check(tag, data_o, exp);
  endtask

  logic [31:0] bases [3];

  initial begin
    checks      = 0;
    failures    = 0;
    bases[0]    = 32'h0000_0000;
    bases[1]    = 32'h0001_0000;
    bases[2]    = 32'h0002_0000;
    RST_n       = 1'b0;
    address_i   = 32'h0;
    data_i      = 32'h0;
    wren_i      = 1'b0;
    byte_mode_i = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_data_o", data_o, 32'h0);
    #2 RST_n = 1'b1;

    // word writes with data = address across all three banks
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 15; i++)
        step(bases[b] + 32'(i), bases[b] + 32'(i), 1'b1, 1'b0);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 15; i++)
        read_word($sformatf("fill_b%0d_w%0d", b, i), bases[b] + 32'(i), 1'b0, bases[b] + 32'(i));

    // byte-lane write merges into the existing word
    step(32'h3, 32'hAABB_CCDD, 1'b1, 1'b0);
    step(32'h3, 32'h1122_3344, 1'b1, 1'b1);
    read_word("byte_merge_word", 32'h3, 1'b0, 32'hAABB_CC44);
    read_word("byte_merge_byte", 32'h3, 1'b1, 32'h0000_0044);
    read_word("byte_read_b1", 32'h1_0005, 1'b1, 32'h0000_0005);

    // unmapped writes must not alias onto word 0 of any bank
    step(32'h3_0000, 32'h1234_5678, 1'b1, 1'b0);
    step(32'h0_1000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(32'h4_0000, 32'hCAFE_F00D, 1'b1, 1'b0);
    read_word("unmapped_30000", 32'h3_0000, 1'b0, 32'h0);
    read_word("unmapped_01000", 32'h0_1000, 1'b0, 32'h0);
    read_word("unmapped_40000", 32'h4_0000, 1'b0, 32'h0);
    read_word("unmapped_keep_b0", 32'h0_0000, 1'b0, 32'h0_0000);
    read_word("unmapped_keep_b1", 32'h1_0000, 1'b0, 32'h1_0000);
    read_word("unmapped_keep_b2", 32'h2_0000, 1'b0, 32'h2_0000);

    // back-to-back reads across banks, one result per edge
    step(32'h0_0001, 32'h0, 1'b0, 1'b0);
    step(32'h1_0001, 32'h0, 1'b0, 1'b0);
    check("b2b_0", data_o, 32'h0_0001);
    step(32'h2_0001, 32'h0, 1'b0, 1'b0);
    check("b2b_1", data_o, 32'h1_0001);
    idle();
    check("b2b_2", data_o, 32'h2_0001);

    // reset pulsed mid-read: output clears at once, writes blocked
    step(32'h5, 32'h0, 1'b0, 1'b0);
    step(32'h5, 32'h0, 1'b0, 1'b0);
    check("pre_reset_data", data_o, 32'h5);
    #2 RST_n = 1'b0;
    #1 check("async_reset_clear", data_o, 32'h0);
    step(32'h5, 32'hDEAD_0000, 1'b1, 1'b0);
    step(32'h5, 32'hDEAD_0000, 1'b1, 1'b0);
    check("during_reset_data", data_o, 32'h0);
    wren_i = 1'b0;
    #2 RST_n = 1'b1;
    step(32'h5, 32'h0, 1'b0, 1'b0);
    check("post_reset_first_edge", data_o, 32'h0);
    idle();
    check("post_reset_mem_kept", data_o, 32'h5);

    // read-before-write on a colliding address
    step(32'h7, 32'h55, 1'b1, 1'b0);
    step(32'h7, 32'h0, 1'b0, 1'b0);
    check("rbw_old", data_o, 32'h7);
    idle();
    check("rbw_new", data_o, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
